input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 117 +++++++++++
 tb/tb_input_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : Multi-channel conditioner for asynchronous board inputs. Each
//            channel has a synchroniser chain, a counter-based debouncer and
//            edge-strobe generation. Each channel can present its debounced
//            level directly or as a push-on/push-off toggle.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int                  CHANNELS        = 2,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter logic [CHANNELS-1:0] INIT_LEVEL      = '0,
    parameter logic [CHANNELS-1:0] TOGGLE_MASK     = '0
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_event
);

    localparam int                c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on which a still-disagreeing sample is accepted.
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // One bit per channel, high on the cycle before that channel's strobe.
    logic [CHANNELS-1:0] w_event;
    logic                r_any;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CNT_W-1:0]     r_cnt;
            logic                   r_deb;
            logic                   r_level;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_sync;
            logic                   w_flip;

            assign w_sync = r_sync[SYNC_STAGES-1];
            // The synchronised input has disagreed with deb long enough.
            assign w_flip = (w_sync != r_deb) && (r_cnt == c_LAST);

            // Synchroniser chain: the only logic that samples raw_in.
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    r_sync <= {SYNC_STAGES{INIT_LEVEL[g]}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in[g]};
                end
            end

            // Stability counter: counts consecutive disagreeing cycles and is
            // cleared on agreement or acceptance, so it never wraps.
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if ((w_sync == r_deb) || w_flip) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            // Debounced level and its edge strobes, updated together.
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    r_deb  <= INIT_LEVEL[g];
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= w_flip & ~r_deb;
                    r_fall <= w_flip &  r_deb;
                    if (w_flip) begin
                        r_deb <= ~r_deb;
                    end
                end
            end

            // Presented level: follows deb, or toggles on each accepted rise.
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    r_level <= INIT_LEVEL[g];
                end else if (TOGGLE_MASK[g]) begin
                    if (w_flip && !r_deb) begin
                        r_level <= ~r_level;
                    end
                end else if (w_flip) begin
                    r_level <= ~r_deb;
                end
            end

            assign w_event[g]    = w_flip;
            assign level_out[g]  = r_level;
            assign rise_pulse[g] = r_rise;
            assign fall_pulse[g] = r_fall;
        end
    endgenerate

    // Single registered strobe covering all channels' edges in a cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_event;
        end
    end

    assign any_event = r_any;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Brief    : Directed self-checking bench for input_conditioner. Instance A
//            uses DEBOUNCE_CYCLES=4, instance B uses DEBOUNCE_CYCLES=1; both
//            have channel 1 in toggle mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    logic       sys_clk;
    logic       reset;
    logic [1:0] raw_a;
    logic [1:0] raw_b;
    logic [1:0] level_a, rise_a, fall_a;
    logic [1:0] level_b, rise_b, fall_b;
    logic       any_a, any_b;

    int n_checks;
    int n_errors;

    input_conditioner #(
        .CHANNELS       (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .INIT_LEVEL     (2'b00),
        .TOGGLE_MASK    (2'b10)
    ) u_dut_a (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .raw_in    (raw_a),
        .level_out (level_a),
        .rise_pulse(rise_a),
        .fall_pulse(fall_a),
        .any_event (any_a)
    );

    input_conditioner #(
        .CHANNELS       (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1),
        .INIT_LEVEL     (2'b00),
        .TOGGLE_MASK    (2'b10)
    ) u_dut_b (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .raw_in    (raw_b),
        .level_out (level_b),
        .rise_pulse(rise_b),
        .fall_pulse(fall_b),
        .any_event (any_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive channel ch of instance A to v, then check n edges. The accepted
    // edge (if any) lands on edge 6 = SYNC_STAGES + DEBOUNCE_CYCLES.
    task automatic run_phase(input int ch, input logic v, input logic lvl_before,
                             input logic lvl_after, input logic exp_rise,
                             input logic exp_fall, input int n);
        raw_a[ch] = v;
        for (int k = 1; k <= n; k++) begin
            tick();
            check($sformatf("ch%0d_v%0d_level_e%0d", ch, v, k), 32'(level_a[ch]),
                  32'((k < 6) ? lvl_before : lvl_after));
            check($sformatf("ch%0d_v%0d_rise_e%0d", ch, v, k), 32'(rise_a[ch]),
                  32'((k == 6) && exp_rise));
            check($sformatf("ch%0d_v%0d_fall_e%0d", ch, v, k), 32'(fall_a[ch]),
                  32'((k == 6) && exp_fall));
            check($sformatf("ch%0d_v%0d_any_e%0d", ch, v, k), 32'(any_a),
                  32'((k == 6) && (exp_rise || exp_fall)));
        end
    endtask

    initial begin
        int any_cnt;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        raw_a    = 2'b00;
        raw_b    = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_level", 32'(level_a), 32'h0);
        check("rst_rise",  32'(rise_a),  32'h0);
        check("rst_fall",  32'(fall_a),  32'h0);
        check("rst_any",   32'(any_a),   32'h0);
        reset = 1'b0;
        tick();
        tick();

        // Follow channel press and release
        run_phase(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10);
        run_phase(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10);

        // Glitch of 3 cycles must be rejected
        any_cnt = 0;
        raw_a[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            any_cnt += int'(any_a);
        end
        raw_a[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            any_cnt += int'(any_a);
        end
        check("glitch_level", 32'(level_a), 32'h0);
        check("glitch_any_count", 32'(any_cnt), 32'h0);

        // Toggle channel: two press/release cycles
        run_phase(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12);
        run_phase(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12);
        run_phase(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12);
        run_phase(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12);

        // Simultaneous rise on both channels
        any_cnt = 0;
        raw_a = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            any_cnt += int'(any_a);
            if (k == 6) begin
                check("both_rise", 32'(rise_a), 32'h3);
                check("both_level", 32'(level_a), 32'h3);
            end
        end
        check("both_any_count", 32'(any_cnt), 32'h1);
        raw_a = 2'b00;
        for (int k = 0; k < 10; k++) tick();
        check("both_release_level", 32'(level_a), 32'h2);

        // Reset mid-debounce aborts the change; timing restarts afterwards
        any_cnt = 0;
        raw_a[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            any_cnt += int'(any_a);
        end
        reset = 1'b1;
        tick();
        check("midrst_level", 32'(level_a), 32'h0);
        check("midrst_rise",  32'(rise_a),  32'h0);
        check("midrst_pre_any", 32'(any_cnt), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("postrst_rise_e%0d", k), 32'(rise_a[0]), 32'(k == 6));
            check($sformatf("postrst_level_e%0d", k), 32'(level_a[0]), 32'(k >= 6));
        end
        raw_a = 2'b00;
        for (int k = 0; k < 10; k++) tick();

        // DEBOUNCE_CYCLES=1: change lands on edge 3
        raw_b[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("d1_level_e%0d", k), 32'(level_b[0]), 32'(k >= 3));
            check($sformatf("d1_rise_e%0d", k),  32'(rise_b[0]),  32'(k == 3));
        end
        raw_b[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("d1_fall_level_e%0d", k), 32'(level_b[0]), 32'(k < 3));
            check($sformatf("d1_fall_e%0d", k),       32'(fall_b[0]),  32'(k == 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
